motor_link_supervisor: RTL and testbench

Parametrised successor to the fibre-side motor gating and page-readback logic of the MCOI XU5 system top. It arms and disarms motor control on the interlock word received over the serial register channel, and runs a watchdog with a trip state machine. It debounces motor statuses with a per-bit stability filter and serves a registered page-readback mux. It sits between the serial_register pair / GBT stream and the motor bank, in the GBT frame clock domain.

---
 rtl/mlsup_pkg.sv | 20 ++
 rtl/status_debouncer.sv | 37 +++
 rtl/motor_link_supervisor.sv | 153 +++++++++++++++
 tb/tb_motor_link_supervisor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlsup_pkg.sv
// Shared types and constants for the motor link supervisor: link states,
// readback page indices and the default readback word.
package mlsup_pkg;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'b00,
      ST_ARMED    = 2'b01,
      ST_TRIPPED  = 2'b10
   } link_state_t;

   localparam logic [7:0]  PAGE_LOOPBACK = 8'd0;
   localparam logic [7:0]  PAGE_BUILD    = 8'd1;
   localparam logic [7:0]  PAGE_PCBREV   = 8'd2;
   localparam logic [7:0]  PAGE_LINK     = 8'd3;

   localparam logic [31:0] PAGE_DEFAULT_WORD = 32'hDEAD_BEEF;
   // ASCII "GEFE"
   localparam logic [31:0] GEFE_INTERLOCK    = 32'h4745_4645;

endpackage

// File: rtl/status_debouncer.sv
// Per-bit stability filter: an output bit follows its input only once the
// last G_DEPTH samples of that bit agree.
module status_debouncer #(
   parameter int G_WIDTH = 64,
   parameter int G_DEPTH = 3
) (
   input  logic               clk_ik,
   input  logic               rstn_ir,
   input  logic [G_WIDTH-1:0] raw,
   output logic [G_WIDTH-1:0] stable
);

   logic [G_WIDTH-1:0] shift_reg [G_DEPTH];
   logic [G_WIDTH-1:0] all_one;
   logic [G_WIDTH-1:0] all_zero;

   always_comb begin
      all_one  = '1;
      all_zero = '1;
      for (int i = 0; i < G_DEPTH; i++) begin
         all_one  = all_one & shift_reg[i];
         all_zero = all_zero & ~shift_reg[i];
      end
   end

   always_ff @(posedge clk_ik or negedge rstn_ir) begin
      if (!rstn_ir) begin
         for (int i = 0; i < G_DEPTH; i++) shift_reg[i] <= '0;
         stable <= '0;
      end else begin
         shift_reg[0] <= raw;
         for (int i = 1; i < G_DEPTH; i++) shift_reg[i] <= shift_reg[i-1];
         stable <= (stable & ~all_zero) | all_one;
      end
   end

endmodule

// File: rtl/motor_link_supervisor.sv
// Motor gating on the serial interlock key with watchdog/trip FSM, status
// debouncing and the registered page-readback mux for serial channel 0.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// DISARMED  | controls forced to 0, waiting for a matching interlock word
// ARMED     | controls pass through, watchdog counts down, reloads on match
// TRIPPED   | controls forced to 0, holdoff counts down, matches ignored
module motor_link_supervisor
   import mlsup_pkg::*;
#(
   parameter int          G_MOTORS           = 16,
   parameter int          G_CTRL_W           = 4,
   parameter int          G_STATUS_W         = 4,
   parameter int          G_DEBOUNCE         = 3,
   parameter logic [31:0] G_INTERLOCK        = GEFE_INTERLOCK,
   parameter int          G_TIMEOUT          = 4000,
   parameter int          G_HOLDOFF          = 40000,
   parameter int          G_STATUS_PAGE_BASE = 16
) (
   input  logic                             clk_ik,
   input  logic                             rstn_ir,
   input  logic                             los_i,
   input  logic [31:0]                      interlock_ib32,
   input  logic                             interlock_valid_i,
   input  logic [31:0]                      pagesel_ib32,
   input  logic                             pagesel_valid_i,
   input  logic [G_MOTORS*G_CTRL_W-1:0]     ctrl_ib,
   input  logic                             ctrl_valid_i,
   output logic [G_MOTORS*G_CTRL_W-1:0]     ctrl_ob,
   input  logic [G_MOTORS*G_STATUS_W-1:0]   status_ib,
   output logic [G_MOTORS*G_STATUS_W-1:0]   status_ob,
   input  logic [31:0]                      build_ib32,
   input  logic [4:0]                       pcbrev_ib5,
   output logic [31:0]                      page_data_ob32,
   output logic                             loopback_o,
   output logic [1:0]                       state_ob2,
   output logic [15:0]                      trip_count_ob16
);

   localparam int WD_W = $clog2(G_TIMEOUT + 1);
   localparam int HO_W = $clog2(G_HOLDOFF + 1);

   link_state_t state;
   logic [WD_W-1:0] watchdog;
   logic [HO_W-1:0] holdoff;
   logic [7:0]      page;
   logic [31:0]     page_next;
   int              page_idx;
   logic            match;
   logic            mismatch;
   logic            wd_expire;
   logic            unused_pagesel;

   assign unused_pagesel = ^pagesel_ib32[30:8];

   assign match     = interlock_valid_i && (interlock_ib32 == G_INTERLOCK);
   assign mismatch  = interlock_valid_i && (interlock_ib32 != G_INTERLOCK);
   // Terminal count: the decrement on this edge would bring the watchdog to 0.
   assign wd_expire = (watchdog <= WD_W'(1)) && !match;
   assign state_ob2 = state;

   always_ff @(posedge clk_ik or negedge rstn_ir) begin
      if (!rstn_ir) begin
         state           <= ST_DISARMED;
         watchdog        <= '0;
         holdoff         <= '0;
         ctrl_ob         <= '0;
         trip_count_ob16 <= '0;
      end else begin
         case (state)
            ST_DISARMED: begin
               ctrl_ob <= '0;
               holdoff <= '0;
               if (match && !los_i) begin
                  state    <= ST_ARMED;
                  watchdog <= WD_W'(G_TIMEOUT);
               end
            end
            ST_ARMED: begin
               if (los_i || mismatch || wd_expire) begin
                  state    <= ST_TRIPPED;
                  watchdog <= '0;
                  holdoff  <= HO_W'(G_HOLDOFF);
                  ctrl_ob  <= '0;
                  if (trip_count_ob16 != 16'hFFFF) trip_count_ob16 <= trip_count_ob16 + 16'd1;
               end else begin
                  watchdog <= match ? WD_W'(G_TIMEOUT) : watchdog - WD_W'(1);
                  if (loopback_o)        ctrl_ob <= '0;
                  else if (ctrl_valid_i) ctrl_ob <= ctrl_ib;
               end
            end
            ST_TRIPPED: begin
               ctrl_ob <= '0;
               if (holdoff <= HO_W'(1)) begin
                  state   <= ST_DISARMED;
                  holdoff <= '0;
               end else begin
                  holdoff <= holdoff - HO_W'(1);
               end
            end
            default: begin
               state    <= ST_DISARMED;
               watchdog <= '0;
               holdoff  <= '0;
               ctrl_ob  <= '0;
            end
         endcase
      end
   end

   status_debouncer #(
      .G_WIDTH (G_MOTORS*G_STATUS_W),
      .G_DEPTH (G_DEBOUNCE)
   ) u_debounce (
      .clk_ik  (clk_ik),
      .rstn_ir (rstn_ir),
      .raw     (status_ib),
      .stable  (status_ob)
   );

   always_comb begin
      page_idx  = int'(page) - G_STATUS_PAGE_BASE;
      page_next = PAGE_DEFAULT_WORD;
      case (page)
         PAGE_LOOPBACK: page_next = {loopback_o, 30'b0, 1'b1};
         PAGE_BUILD:    page_next = build_ib32;
         PAGE_PCBREV:   page_next = {27'b0, pcbrev_ib5};
         PAGE_LINK:     page_next = {14'b0, state_ob2, trip_count_ob16};
         default: begin
            if (page_idx >= 0 && page_idx < G_MOTORS) begin
               page_next = '0;
               page_next[G_STATUS_W-1:0] = status_ob[page_idx*G_STATUS_W +: G_STATUS_W];
            end
         end
      endcase
   end

   always_ff @(posedge clk_ik or negedge rstn_ir) begin
      if (!rstn_ir) begin
         page           <= '0;
         loopback_o     <= 1'b0;
         page_data_ob32 <= 32'h0000_0001;
      end else begin
         if (pagesel_valid_i) begin
            page       <= pagesel_ib32[7:0];
            loopback_o <= pagesel_ib32[31];
         end
         page_data_ob32 <= page_next;
      end
   end

endmodule

// File: tb/tb_motor_link_supervisor.sv
// Bench for motor_link_supervisor: directed stimulus pushes expected values
// with a due cycle into a scoreboard; a monitor compares them at negedge.
module tb_motor_link_supervisor;

   localparam logic [31:0] KEY = 32'h4745_4645;
   localparam int S_STATE = 0, S_CTRL = 1, S_STATUS = 2, S_PAGE = 3, S_LOOP = 4, S_TRIP = 5;
   localparam logic [63:0] CTRL_5 = 64'h5555_5555_5555_5555;
   localparam logic [63:0] CTRL_A = 64'hAAAA_AAAA_AAAA_AAAA;

   logic        clk_ik = 1'b0;
   logic        rstn_ir;
   logic        los_i;
   logic [31:0] interlock_ib32;
   logic        interlock_valid_i;
   logic [31:0] pagesel_ib32;
   logic        pagesel_valid_i;
   logic [63:0] ctrl_ib;
   logic        ctrl_valid_i;
   logic [63:0] ctrl_ob;
   logic [63:0] status_ib;
   logic [63:0] status_ob;
   logic [31:0] build_ib32;
   logic [4:0]  pcbrev_ib5;
   logic [31:0] page_data_ob32;
   logic        loopback_o;
   logic [1:0]  state_ob2;
   logic [15:0] trip_count_ob16;

   typedef struct {
      int          due;
      int          sel;
      logic [63:0] want;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   motor_link_supervisor #(
      .G_MOTORS           (16),
      .G_CTRL_W           (4),
      .G_STATUS_W         (4),
      .G_DEBOUNCE         (3),
      .G_INTERLOCK        (KEY),
      .G_TIMEOUT          (4000),
      .G_HOLDOFF          (40000),
      .G_STATUS_PAGE_BASE (16)
   ) dut (
      .clk_ik            (clk_ik),
      .rstn_ir           (rstn_ir),
      .los_i             (los_i),
      .interlock_ib32    (interlock_ib32),
      .interlock_valid_i (interlock_valid_i),
      .pagesel_ib32      (pagesel_ib32),
      .pagesel_valid_i   (pagesel_valid_i),
      .ctrl_ib           (ctrl_ib),
      .ctrl_valid_i      (ctrl_valid_i),
      .ctrl_ob           (ctrl_ob),
      .status_ib         (status_ib),
      .status_ob         (status_ob),
      .build_ib32        (build_ib32),
      .pcbrev_ib5        (pcbrev_ib5),
      .page_data_ob32    (page_data_ob32),
      .loopback_o        (loopback_o),
      .state_ob2         (state_ob2),
      .trip_count_ob16   (trip_count_ob16)
   );

   always #5 clk_ik = ~clk_ik;
   always @(posedge clk_ik) cyc <= cyc + 1;

   function automatic logic [63:0] actual(int sel);
      case (sel)
         S_STATE:  return {62'b0, state_ob2};
         S_CTRL:   return ctrl_ob;
         S_STATUS: return status_ob;
         S_PAGE:   return {32'b0, page_data_ob32};
         S_LOOP:   return {63'b0, loopback_o};
         S_TRIP:   return {48'b0, trip_count_ob16};
         default:  return '0;
      endcase
   endfunction

   // n = number of further rising edges before the value must be visible
   task automatic expect_in(int sel, logic [63:0] val, int n, string name);
      exp_t e;
      e.due  = cyc + n;
      e.sel  = sel;
      e.want = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk_ik);
   endtask

   task automatic arm(logic [63:0] ctrl_word);
      interlock_ib32    = KEY;
      interlock_valid_i = 1'b1;
      ctrl_valid_i      = 1'b1;
      ctrl_ib           = ctrl_word;
      expect_in(S_STATE, 64'd1, 1, "arm_state");
      tick(1);
      interlock_valid_i = 1'b0;
      interlock_ib32    = '0;
   endtask

   task automatic read_page(logic [31:0] sel_word, logic [63:0] want, string name);
      pagesel_ib32    = sel_word;
      pagesel_valid_i = 1'b1;
      expect_in(S_PAGE, want, 2, name);
      tick(1);
      pagesel_valid_i = 1'b0;
      tick(2);
   endtask

   always begin
      @(negedge clk_ik);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            n_checks++;
            if (actual(sb[i].sel) !== sb[i].want) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h (cycle %0d)", sb[i].name,
                        actual(sb[i].sel), sb[i].want, cyc);
            end
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: check never sampled, expected %h (due %0d)", sb[i].name,
                     sb[i].want, sb[i].due);
            sb.delete(i);
         end
      end
   end

   initial begin
      int t_trip;
      int pages [7];
      logic [63:0] page_want [7];

      rstn_ir = 1'b0;
      los_i = 1'b0;
      interlock_ib32 = '0;
      interlock_valid_i = 1'b0;
      pagesel_ib32 = '0;
      pagesel_valid_i = 1'b0;
      ctrl_ib = '0;
      ctrl_valid_i = 1'b0;
      status_ib = '0;
      build_ib32 = 32'h1234_5678;
      pcbrev_ib5 = 5'h13;

      tick(2);
      expect_in(S_STATE, 64'd0, 0, "rst_state");
      expect_in(S_CTRL, 64'd0, 0, "rst_ctrl");
      expect_in(S_PAGE, 64'd1, 0, "rst_page");
      expect_in(S_LOOP, 64'd0, 0, "rst_loopback");
      expect_in(S_TRIP, 64'd0, 0, "rst_trip");
      expect_in(S_STATUS, 64'd0, 0, "rst_status");
      tick(1);
      rstn_ir = 1'b1;
      tick(1);

      expect_in(S_CTRL, 64'd0, 1, "arm_ctrl_still_0");
      expect_in(S_CTRL, CTRL_5, 2, "arm_ctrl_pass");
      arm(CTRL_5);
      tick(1);

      read_page(32'd3, 64'h0001_0000, "page3_armed");

      pagesel_ib32 = 32'h8000_0000;
      pagesel_valid_i = 1'b1;
      expect_in(S_LOOP, 64'd1, 1, "loop_set");
      expect_in(S_CTRL, CTRL_5, 1, "loop_ctrl_lag");
      expect_in(S_CTRL, 64'd0, 2, "loop_ctrl_zero");
      expect_in(S_PAGE, 64'h8000_0001, 2, "loop_page0");
      expect_in(S_STATE, 64'd1, 2, "loop_no_trip");
      tick(1);
      pagesel_valid_i = 1'b0;
      tick(2);

      pagesel_ib32 = 32'h0;
      pagesel_valid_i = 1'b1;
      ctrl_ib = CTRL_A;
      expect_in(S_LOOP, 64'd0, 1, "loop_clear");
      expect_in(S_CTRL, 64'd0, 1, "loop_clear_lag");
      expect_in(S_CTRL, CTRL_A, 2, "loop_clear_ctrl");
      expect_in(S_PAGE, 64'd1, 2, "loop_clear_page0");
      tick(1);
      pagesel_valid_i = 1'b0;
      tick(1);
      ctrl_valid_i = 1'b0;
      ctrl_ib = '0;
      expect_in(S_CTRL, CTRL_A, 2, "ctrl_hold");
      tick(2);

      // Reload then starve: trip lands 4000 edges after the reload edge
      interlock_ib32 = KEY;
      interlock_valid_i = 1'b1;
      expect_in(S_STATE, 64'd1, 4000, "wd_before_trip");
      expect_in(S_CTRL, CTRL_A, 4000, "wd_ctrl_before");
      expect_in(S_STATE, 64'd2, 4001, "wd_trip_state");
      expect_in(S_CTRL, 64'd0, 4001, "wd_trip_ctrl");
      expect_in(S_TRIP, 64'd1, 4001, "wd_trip_count");
      tick(1);
      interlock_valid_i = 1'b0;
      interlock_ib32 = '0;
      tick(4000);
      t_trip = cyc;
      expect_in(S_STATE, 64'd2, 39999, "holdoff_last");
      expect_in(S_STATE, 64'd0, 40000, "holdoff_done");

      tick(100);
      interlock_ib32 = KEY;
      interlock_valid_i = 1'b1;
      pagesel_ib32 = 32'd3;
      pagesel_valid_i = 1'b1;
      expect_in(S_STATE, 64'd2, 1, "holdoff_match_ignored");
      expect_in(S_PAGE, 64'h0002_0001, 2, "page3_tripped");
      tick(1);
      interlock_valid_i = 1'b0;
      interlock_ib32 = '0;
      pagesel_valid_i = 1'b0;
      tick(t_trip + 40000 - cyc);
      expect_in(S_PAGE, 64'h0000_0001, 1, "page3_disarmed");
      tick(2);

      rstn_ir = 1'b0;
      tick(1);
      rstn_ir = 1'b1;
      tick(1);
      arm(CTRL_5);
      tick(1);
      expect_in(S_CTRL, CTRL_5, 0, "rearm_ctrl");
      interlock_ib32 = 32'h0;
      interlock_valid_i = 1'b1;
      los_i = 1'b1;
      expect_in(S_STATE, 64'd2, 1, "dual_trip_state");
      expect_in(S_CTRL, 64'd0, 1, "dual_trip_ctrl");
      expect_in(S_TRIP, 64'd1, 1, "dual_trip_count");
      expect_in(S_TRIP, 64'd1, 3, "dual_trip_single");
      tick(1);
      interlock_valid_i = 1'b0;
      los_i = 1'b0;
      tick(3);
      rstn_ir = 1'b0;
      expect_in(S_TRIP, 64'd0, 0, "rst_trip_clear");
      expect_in(S_STATE, 64'd0, 0, "rst_tripped_state");
      tick(1);
      rstn_ir = 1'b1;
      tick(1);

      // Motor 5 bit 0 is status bit 20; motor 15 occupies bits 63:60
      status_ib[20] = 1'b1;
      expect_in(S_STATUS, 64'd0, 1, "glitch_hi");
      tick(1);
      status_ib[20] = 1'b0;
      expect_in(S_STATUS, 64'd0, 1, "glitch_lo");
      tick(1);
      status_ib[20] = 1'b1;
      status_ib[63:60] = 4'hB;
      expect_in(S_STATUS, 64'd0, 1, "stable_1");
      expect_in(S_STATUS, 64'd0, 2, "stable_2");
      expect_in(S_STATUS, 64'd0, 3, "stable_3");
      expect_in(S_STATUS, 64'hB000_0000_0010_0000, 4, "stable_update");
      tick(6);

      pages = '{21, 31, 1, 2, 3, 200, 16};
      page_want = '{64'h1, 64'hB, 64'h1234_5678, 64'h13, 64'h0, 64'hDEAD_BEEF, 64'h0};
      for (int i = 0; i < 7; i++)
         read_page(pages[i], page_want[i], $sformatf("page_%0d", pages[i]));

      read_page(32'd0, 64'd1, "page0_back");
      arm(CTRL_5);
      tick(2);
      expect_in(S_CTRL, CTRL_5, 0, "pre_rst_ctrl");
      tick(1);
      rstn_ir = 1'b0;
      expect_in(S_CTRL, 64'd0, 0, "async_rst_ctrl");
      expect_in(S_STATE, 64'd0, 0, "async_rst_state");
      expect_in(S_TRIP, 64'd0, 0, "async_rst_trip");
      expect_in(S_PAGE, 64'd1, 0, "async_rst_page");
      tick(2);
      rstn_ir = 1'b1;
      tick(3);
      #2;

      foreach (sb[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: check left pending, expected %h (due %0d)", sb[i].name,
                  sb[i].want, sb[i].due);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
